// File: rtl/counter_sequencer.sv
// Purpose : command-side sequencer that programs an event counter for N passes of a job.
// Latency : handshake at t -> LOAD at t+1, first enable at t+2; cnt_event at k -> pass_done/done at k+1.
// Backpr. : cmd_ready is high only in IDLE; commands presented while busy wait until IDLE.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             job handshake; cmd_end_val, cmd_repeat latched on accept
//   cmd_abort                       cancels a job in progress (ignored in IDLE)
//   cnt_end_val/cnt_load/cnt_reset/cnt_enable  counter programming pins
//   cnt_event                       counter end event, sampled only in RUN
//   pass_idx, pass_done, done, busy status towards tile control
//   timeout                         watchdog pulse
//
// Optional watchdog: define SEQ_WATCHDOG_EN to abandon a RUN pass that sees no
// cnt_event within WDOG_CYCLES cycles. Without it, timeout is tied to 0.
module counter_sequencer #(
  parameter int COUNTER_WIDTH = 32,
  parameter int REPEAT_WIDTH  = 16,
  parameter int WDOG_CYCLES   = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [COUNTER_WIDTH-1:0] cmd_end_val,
  input  logic [REPEAT_WIDTH-1:0]  cmd_repeat,
  input  logic                     cmd_abort,
  output logic [COUNTER_WIDTH-1:0] cnt_end_val,
  output logic                     cnt_load,
  output logic                     cnt_reset,
  output logic                     cnt_enable,
  input  logic                     cnt_event,
  output logic [REPEAT_WIDTH-1:0]  pass_idx,
  output logic                     pass_done,
  output logic                     done,
  output logic                     busy,
  output logic                     timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [COUNTER_WIDTH-1:0] end_val_q;
  logic [REPEAT_WIDTH-1:0]  repeat_q;
  logic                     rst_pulse_q;   // counter reset on the IDLE cycle after abort/timeout
  logic                     pass_done_q;
  logic                     abort_act;
  logic                     evt_ok;        // event that completes a pass (abort wins)
  logic                     last_pass;
  logic                     wdog_expire;

  assign abort_act = cmd_abort && (state != S_IDLE);
  assign evt_ok    = (state == S_RUN) && cnt_event && !abort_act;
  assign last_pass = (pass_idx == repeat_q - REPEAT_WIDTH'(1));

`ifdef SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              timeout_q;

  // Expiry is judged on the WDOG_CYCLES-th RUN cycle; an event in that same
  // cycle still completes the pass.
  assign wdog_expire = (state == S_RUN) && !cnt_event &&
                       (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_LOAD)
        wdog_cnt <= '0;
      else if (state == S_RUN)
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      timeout_q <= wdog_expire && !abort_act;
    end
  end

  assign timeout = timeout_q;
`else
  // Keeps the watchdog parameter referenced in builds without the watchdog.
  logic [WDOG_W-1:0] unused_wdog_cfg;
  assign unused_wdog_cfg = WDOG_W'(WDOG_CYCLES);
  assign wdog_expire     = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cmd_valid) state_nxt = (cmd_repeat == '0) ? S_DONE : S_LOAD;
      S_LOAD: state_nxt = S_RUN;
      S_RUN: begin
        if (cnt_event)        state_nxt = last_pass ? S_DONE : S_LOAD;
        else if (wdog_expire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_act) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      end_val_q   <= '0;
      repeat_q    <= '0;
      pass_idx    <= '0;
      rst_pulse_q <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      pass_done_q <= evt_ok;
      rst_pulse_q <= abort_act || wdog_expire;
      if (state == S_IDLE && cmd_valid) begin
        end_val_q <= cmd_end_val;
        repeat_q  <= cmd_repeat;
      end
      // Index is 0 whenever the sequencer sits in IDLE; DONE keeps the last index.
      if (state == S_IDLE || state_nxt == S_IDLE)
        pass_idx <= '0;
      else if (evt_ok && !last_pass)
        pass_idx <= pass_idx + REPEAT_WIDTH'(1);
    end
  end

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign cnt_load    = (state == S_LOAD);
  assign cnt_enable  = (state == S_RUN);
  assign cnt_reset   = (state == S_LOAD) || (state == S_DONE) || rst_pulse_q;
  assign done        = (state == S_DONE);
  assign pass_done   = pass_done_q;
  assign cnt_end_val = end_val_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: each job is expanded from its parameters into an
// expected per-cycle timeline (rows of flags/pass index plus the stimulus for
// that cycle), which is then driven and compared cycle by cycle.
module tb_counter_sequencer;
  localparam int CW = 32;
  localparam int RW = 16;
  localparam int WD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_abort;
  logic [CW-1:0] cmd_end_val, cnt_end_val;
  logic [RW-1:0] cmd_repeat, pass_idx;
  logic          cnt_load, cnt_reset, cnt_enable, cnt_event;
  logic          pass_done, done, busy, timeout;

  counter_sequencer #(.COUNTER_WIDTH(CW), .REPEAT_WIDTH(RW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_end_val(cmd_end_val), .cmd_repeat(cmd_repeat), .cmd_abort(cmd_abort),
    .cnt_end_val(cnt_end_val), .cnt_load(cnt_load), .cnt_reset(cnt_reset),
    .cnt_enable(cnt_enable), .cnt_event(cnt_event), .pass_idx(pass_idx),
    .pass_done(pass_done), .done(done), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected flag word: {ready, busy, load, cnt_reset, enable, pass_done, done, timeout}
  logic [7:0]    e_flags [256];
  logic [RW-1:0] e_idx   [256];
  logic          s_evt   [256];
  logic          s_abt   [256];
  int            run_len [256];   // RUN cycles per pass; 0 = pass never sees an event
  int            nrows;
  logic          carry_rst = 1'b0;
  logic          carry_to  = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add_row(input logic [7:0] f, input logic [RW-1:0] idx, input logic ev, input logic ab);
    e_flags[nrows] = f;
    e_idx[nrows]   = idx;
    s_evt[nrows]   = ev;
    s_abt[nrows]   = ab;
    nrows++;
  endtask

  // Expand one job into its expected timeline, starting at the handshake cycle.
  task automatic build(input logic [RW-1:0] rep, input int abort_row);
    bit ended = 0;
    int p;
    nrows = 0;
    add_row({3'b100, carry_rst, 3'b000, carry_to}, '0, 1'($urandom), 1'($urandom));
    carry_rst = 1'b0;
    carry_to  = 1'b0;
    if (rep == '0) begin
      add_row(8'b0101_0010, '0, 1'($urandom), 1'b0);
    end else begin
      for (p = 0; p < int'(rep) && nrows < 200 && !ended; p++) begin
        add_row({5'b01110, 1'(p > 0), 2'b00}, RW'(p), 1'($urandom), 1'b0);
        if (run_len[p] == 0) begin
          for (int k = 0; k < WD; k++) add_row(8'b0100_1000, RW'(p), 1'b0, 1'b0);
          ended     = 1;
          carry_rst = 1'b1;
          carry_to  = 1'b1;
        end else begin
          for (int k = 0; k < run_len[p]; k++)
            add_row(8'b0100_1000, RW'(p), 1'(k == run_len[p] - 1), 1'b0);
        end
      end
      if (!ended && p == int'(rep))
        add_row(8'b0101_0110, rep - RW'(1), 1'($urandom), 1'b0);
    end
    if (abort_row > 0 && abort_row < nrows) begin
      s_abt[abort_row] = 1'b1;
      s_evt[abort_row] = 1'b1;   // abort must win over a coincident event
      nrows     = abort_row + 1;
      carry_rst = 1'b1;
      carry_to  = 1'b0;
    end
  endtask

  task automatic run_rows(input int n, input logic [CW-1:0] ev, input logic [RW-1:0] rp);
    for (int i = 0; i < n; i++) begin
      cmd_valid   = (i == 0) ? 1'b1 : 1'($urandom);
      cmd_end_val = (i == 0) ? ev : CW'($urandom);
      cmd_repeat  = (i == 0) ? rp : RW'($urandom);
      cnt_event   = s_evt[i];
      cmd_abort   = s_abt[i];
      check_eq($sformatf("flags[%0d]", i),
               {cmd_ready, busy, cnt_load, cnt_reset, cnt_enable, pass_done, done, timeout},
               e_flags[i]);
      check_eq($sformatf("pass_idx[%0d]", i), pass_idx, e_idx[i]);
      if (i > 0) check_eq($sformatf("end_val[%0d]", i), cnt_end_val, ev);
      @(posedge clk); #1;
    end
  endtask

  task automatic job(input logic [CW-1:0] ev, input logic [RW-1:0] rp, input int abort_row);
    build(rp, abort_row);
    run_rows(nrows, ev, rp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      cnt_event = 1'($urandom);
      cmd_abort = 1'($urandom);
      check_eq("idle_flags",
               {cmd_ready, busy, cnt_load, cnt_reset, cnt_enable, pass_done, done, timeout},
               {3'b100, carry_rst, 3'b000, carry_to});
      check_eq("idle_idx", pass_idx, '0);
      carry_rst = 1'b0;
      carry_to  = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_abort = 1'b0; cnt_event = 1'b0;
    cmd_end_val = '0; cmd_repeat = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_flags",
             {cmd_ready, busy, cnt_load, cnt_reset, cnt_enable, pass_done, done, timeout},
             8'b1000_0000);
    check_eq("rst_idx", pass_idx, '0);
    check_eq("rst_end_val", cnt_end_val, '0);
    reset = 1'b0;

    // Basic job: end 5, three passes, event on the 4th RUN cycle of each pass.
    for (int p = 0; p < 3; p++) run_len[p] = 4;
    job(32'd5, 16'd3, -1);
    idle(1);

    // Zero repeat: straight to DONE, no load or enable.
    job(32'h1234, 16'd0, -1);
    idle(1);

    // Abort coincident with an event on the 2nd RUN cycle of pass 0.
    run_len[0] = 4; run_len[1] = 4;
    job(32'hBEEF, 16'd2, 3);
    idle(2);

    // Reset during RUN of pass 1, then a normal job.
    for (int p = 0; p < 3; p++) run_len[p] = 4;
    build(16'd3, -1);
    run_rows(8, 32'hA5, 16'd3);
    cmd_valid = 1'b0; cnt_event = 1'b0; cmd_abort = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("midrst_flags",
             {cmd_ready, busy, cnt_load, cnt_reset, cnt_enable, pass_done, done, timeout},
             8'b1000_0000);
    check_eq("midrst_idx", pass_idx, '0);
    check_eq("midrst_end_val", cnt_end_val, '0);
    carry_rst = 1'b0; carry_to = 1'b0;
    for (int p = 0; p < 2; p++) run_len[p] = 1 + p;
    job(32'h77, 16'd2, -1);

    // Maximum repeat is legal; stop it with an abort after a few passes.
    for (int p = 0; p < 256; p++) run_len[p] = $urandom_range(1, 3);
    job(32'hFFFF_FFFF, 16'hFFFF, 12);
    idle(1);

`ifdef SEQ_WATCHDOG_EN
    // No event: timeout after WD RUN cycles. Event on the WD-th cycle: success.
    run_len[0] = 0;
    job(32'h9, 16'd1, -1);
    idle(1);
    run_len[0] = WD;
    job(32'h9, 16'd1, -1);
    idle(1);
`endif

    // Randomized jobs, back-to-back or with idle gaps, optional aborts.
    for (int j = 0; j < 30; j++) begin
      for (int p = 0; p < 8; p++) run_len[p] = $urandom_range(1, 6);
      job(CW'($urandom), RW'($urandom_range(0, 4)),
          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : -1);
      idle($urandom_range(0, 2));
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1);
  end
endmodule
